// File: rtl/cpu_sequencer_pkg.sv
// Shared types and constants for the multi-cycle RV32 control sequencer.
// Pure declarations: no logic and no latency.
// No handshakes of its own; the users of these types apply the backpressure.
package cpu_seq_pkg;

   // Sequencer states. The encoding is fixed here so that every user agrees on it.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_MEM   = 3'd3,
      ST_WB    = 3'd4,
      ST_HALT  = 3'd5
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // Loads and stores are the only opcodes that need a data-memory phase.
   function automatic logic needs_mem(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   // Stores and branches have no rd, so they must not strobe the register file.
   function automatic logic writes_reg(input logic [6:0] op);
      return !((op == OP_STORE) || (op == OP_BRANCH));
   endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundles the sequencer's control, memory-handshake and status signals.
// Wires only, so it adds no latency.
// mem_ack completes the outstanding fetch_req/data_req; requests stay high until then.
interface cpu_sequencer_if #(
   parameter int CNT_W = 32
);
   logic             run;
   logic             halt_req;
   logic             mem_ack;
   logic [31:0]      mem_rdata;
   logic             fetch_req;
   logic             data_req;
   logic             data_we;
   logic [31:0]      instr;
   logic             pc_en;
   logic             pc_in_en;
   logic             reg_we;
   logic             busy;
   logic             bus_error;
   logic [CNT_W-1:0] retired;

   // Sequencer side.
   modport master (
      input  run, halt_req, mem_ack, mem_rdata,
      output fetch_req, data_req, data_we, instr, pc_en, pc_in_en,
             reg_we, busy, bus_error, retired
   );

   // Core / memory / test-environment side.
   modport slave (
      output run, halt_req, mem_ack, mem_rdata,
      input  fetch_req, data_req, data_we, instr, pc_en, pc_in_en,
             reg_we, busy, bus_error, retired
   );
endinterface

// File: rtl/cpu_sequencer_timeout_ctr.sv
// Counts the cycles a bus request has waited, with clear and saturating increment.
// o_expired is combinational in the cycle where this increment would reach LIMIT.
// No handshake: the counter advances only while i_inc is high, and i_clr wins.
module seq_timeout_ctr #(
   parameter int LIMIT = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_expired
);
   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] MAX_CNT  = W'(LIMIT);
   localparam logic [W-1:0] LAST_CNT = W'(LIMIT - 1);

   logic [W-1:0] r_cnt;

   // Wait counter: clear has priority; the increment saturates at LIMIT.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != MAX_CNT)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = i_inc && (r_cnt == LAST_CNT);
endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32 control FSM: FETCH -> EXEC -> (MEM) -> WB, with retire count and bus timeout.
// An instruction takes 3 cycles (4 with MEM) plus one cycle for each memory wait state.
// fetch_req/data_req stay high until mem_ack; after ACK_TIMEOUT cycles without it the core halts.
module cpu_sequencer
   import cpu_seq_pkg::*;
#(
   parameter int ACK_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic            clock,
   input  logic            reset,
   cpu_sequencer_if.master bus
);
   state_t            r_state;
   state_t            w_next;
   logic [31:0]       r_instr;
   logic [CNT_W-1:0]  r_retired;
   logic              r_bus_error;

   logic              w_req_active;
   logic              w_ctr_clr;
   logic              w_ctr_inc;
   logic              w_expired;
   logic              w_timeout;
   logic [6:0]        w_op;

   assign w_op         = r_instr[6:0];
   assign w_req_active = (r_state == ST_FETCH) || (r_state == ST_MEM);
   assign w_ctr_inc    = w_req_active && !bus.mem_ack;
   // Every state change clears the counter, so each FETCH and MEM starts counting from zero.
   assign w_ctr_clr    = (w_next != r_state);
   assign w_timeout    = w_req_active && !bus.mem_ack && w_expired;

   seq_timeout_ctr #(
      .LIMIT (ACK_TIMEOUT)
   ) u_timeout (
      .clock     (clock),
      .reset     (reset),
      .i_clr     (w_ctr_clr),
      .i_inc     (w_ctr_inc),
      .o_expired (w_expired)
   );

   // State register. Reset drops every request and strobe at once, because they decode from the state.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic. An ack arriving in the expiry cycle still completes the transfer.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (bus.run && !bus.halt_req) w_next = ST_FETCH;
         end
         ST_FETCH: begin
            if (bus.mem_ack)    w_next = ST_EXEC;
            else if (w_expired) w_next = ST_HALT;
         end
         ST_EXEC: begin
            w_next = needs_mem(w_op) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            if (bus.mem_ack)    w_next = ST_WB;
            else if (w_expired) w_next = ST_HALT;
         end
         ST_WB: begin
            w_next = (bus.halt_req || !bus.run) ? ST_HALT : ST_FETCH;
         end
         ST_HALT: begin
            if (!bus.run && !bus.halt_req) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Moore output decode. The PC moves only in WB, and data_we holds steady because instr is latched.
   always_comb begin
      bus.fetch_req = 1'b0;
      bus.data_req  = 1'b0;
      bus.data_we   = 1'b0;
      bus.pc_en     = 1'b0;
      bus.pc_in_en  = 1'b0;
      bus.reg_we    = 1'b0;
      bus.busy      = (r_state != ST_IDLE) && (r_state != ST_HALT);
      case (r_state)
         ST_FETCH: bus.fetch_req = 1'b1;
         ST_EXEC:  bus.data_we   = (w_op == OP_STORE);
         ST_MEM: begin
            bus.data_req = 1'b1;
            bus.data_we  = (w_op == OP_STORE);
         end
         ST_WB: begin
            bus.pc_en    = 1'b1;
            bus.pc_in_en = 1'b1;
            bus.reg_we   = writes_reg(w_op);
         end
         default: ;
      endcase
   end

   // Capture the instruction word when the fetch completes.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_instr <= '0;
      end else if ((r_state == ST_FETCH) && bus.mem_ack) begin
         r_instr <= bus.mem_rdata;
      end
   end

   // Count retired instructions (one per WB), wrapping naturally.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_retired <= '0;
      end else if (r_state == ST_WB) begin
         r_retired <= r_retired + 1'b1;
      end
   end

   // Sticky bus-error flag. Only reset clears it.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_bus_error <= 1'b0;
      end else if (w_timeout) begin
         r_bus_error <= 1'b1;
      end
   end

   assign bus.instr     = r_instr;
   assign bus.retired   = r_retired;
   assign bus.bus_error = r_bus_error;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized scoreboard bench for cpu_sequencer with ACK_TIMEOUT=4.
// The driver queues an expected record for each instruction; the negedge monitor checks it at the WB pulse.
// Memory wait states, spurious acks, halt, timeout and asynchronous reset are all exercised.
module tb_cpu_sequencer;
   localparam int TO = 4;

   typedef struct {
      logic [31:0] instr;
      bit          is_mem;
      bit          we;
      bit          reg_we;
      int          fw;
      int          dw;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   cpu_sequencer_if #(.CNT_W(32)) bus ();

   cpu_sequencer #(
      .ACK_TIMEOUT (TO),
      .CNT_W       (32)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   model_retired = 0;

   // Monitor bookkeeping for the instruction in flight.
   bit   in_instr = 0;
   int   cyc, fcnt, dcnt, wecnt;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference behaviour of one instruction, derived directly from its opcode class.
   function automatic exp_t make_exp(input logic [31:0] instr, input int fw, input int dw);
      exp_t       e;
      logic [6:0] op;
      op       = instr[6:0];
      e.instr  = instr;
      e.is_mem = (op == 7'b0000011) || (op == 7'b0100011);
      e.we     = (op == 7'b0100011);
      e.reg_we = !((op == 7'b0100011) || (op == 7'b1100011));
      e.fw     = fw;
      e.dw     = dw;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 4))
         0: w[6:0] = 7'b0000011;
         1: w[6:0] = 7'b0100011;
         2: w[6:0] = 7'b1100011;
         3: w[6:0] = 7'b0010011;
         default: ;
      endcase
      return w;
   endfunction

   // Waits (bounded) for a request; returns at the negedge of the request's first cycle.
   task automatic wait_req(input int sel, output bit ok);
      ok = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (((sel == 0) ? bus.fetch_req : bus.data_req) === 1'b1) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL wait_%s: no request within 40 cycles, expected one", (sel == 0) ? "fetch" : "data");
      end
   endtask

   // Holds off `waits` cycles, then acks so the ack spans exactly one rising edge.
   task automatic ack_req(input int waits, input logic [31:0] data);
      repeat (waits) @(negedge clock);
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = data;
      @(negedge clock);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
   endtask

   task automatic run_instr(input logic [31:0] instr, input int fw, input int dw);
      exp_t e;
      bit   ok;
      e = make_exp(instr, fw, dw);
      exp_q.push_back(e);
      wait_req(0, ok);
      if (!ok) return;
      ack_req(fw, instr);
      if (e.is_mem) begin
         wait_req(1, ok);
         if (!ok) return;
         ack_req(dw, $urandom);
      end else if ($urandom_range(0, 1) == 1) begin
         // A stray ack during EXEC must have no effect.
         bus.mem_ack = 1'b1;
         @(negedge clock);
         bus.mem_ack = 1'b0;
      end
   endtask

   // Monitor: follows each instruction from its first fetch cycle and scores it at the WB pulse.
   always @(negedge clock) begin
      if (reset !== 1'b0) begin
         in_instr = 0;
      end else begin
         check("pc_en_pairing", 32'(bus.pc_in_en), 32'(bus.pc_en));
         if (!in_instr && bus.fetch_req === 1'b1) begin
            in_instr = 1;
            cyc = 0; fcnt = 0; dcnt = 0; wecnt = 0;
         end
         if (in_instr) begin
            cyc   = cyc + 1;
            fcnt  = fcnt + int'(bus.fetch_req);
            dcnt  = dcnt + int'(bus.data_req);
            wecnt = wecnt + int'(bus.data_req && bus.data_we);
            if (bus.busy !== 1'b1) in_instr = 0;
         end
         if (bus.pc_en === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_pc_en: pc_en=1, expected 0 (no instruction pending, t=%0t)", $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("wb_instr",     bus.instr, e.instr);
               check("wb_reg_we",    32'(bus.reg_we), 32'(e.reg_we));
               check("wb_busy",      32'(bus.busy), 32'd1);
               check("fetch_cycles", fcnt, e.fw + 1);
               check("data_cycles",  dcnt, e.is_mem ? e.dw + 1 : 0);
               check("store_cycles", wecnt, e.we ? e.dw + 1 : 0);
               check("latency",      cyc, e.fw + 3 + (e.is_mem ? e.dw + 1 : 0));
               check("retired_pre",  bus.retired, model_retired);
               model_retired++;
            end
            in_instr = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ok;
      reset         = 1'b1;
      bus.run       = 1'b0;
      bus.halt_req  = 1'b0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      repeat (3) @(negedge clock);
      check("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
      check("rst_data_req",  32'(bus.data_req), 32'd0);
      check("rst_busy",      32'(bus.busy), 32'd0);
      check("rst_retired",   bus.retired, 32'd0);
      check("rst_bus_error", 32'(bus.bus_error), 32'd0);
      check("rst_instr",     bus.instr, 32'd0);
      check("rst_pc_en",     32'(bus.pc_en), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("idle_busy", 32'(bus.busy), 32'd0);

      // Directed cases, then the timeout boundary (ack in the expiry cycle), then random traffic.
      bus.run = 1'b1;
      run_instr(32'h00500093, 0, 0);
      run_instr(32'h0000A103, 2, 3);
      run_instr(32'h0020A023, 0, 1);
      run_instr(32'h00208063, TO - 1, 0);
      run_instr(32'h0000A103, 0, TO - 1);
      for (int i = 0; i < 30; i++)
         run_instr(rand_instr(), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));

      // Halt requested in MEM: the load finishes, then the core holds in HALT.
      exp_q.push_back(make_exp(32'h0040A183, 0, 1));
      wait_req(0, ok);
      ack_req(0, 32'h0040A183);
      wait_req(1, ok);
      bus.halt_req = 1'b1;
      ack_req(1, $urandom);
      @(negedge clock);
      bus.halt_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("halt_busy",  32'(bus.busy), 32'd0);
         check("halt_fetch", 32'(bus.fetch_req), 32'd0);
         @(negedge clock);
      end
      check("halt_retired", bus.retired, model_retired);
      bus.run = 1'b0;
      @(negedge clock);
      bus.run = 1'b1;
      run_instr(32'h00100113, 1, 0);

      // Fetch timeout: no ack, so after TO cycles the core halts with bus_error set.
      wait_req(0, ok);
      repeat (TO - 1) @(negedge clock);
      check("to_fetch_held", 32'(bus.fetch_req), 32'd1);
      check("to_no_err_yet", 32'(bus.bus_error), 32'd0);
      @(negedge clock);
      check("to_bus_error", 32'(bus.bus_error), 32'd1);
      check("to_busy",      32'(bus.busy), 32'd0);
      check("to_fetch_off", 32'(bus.fetch_req), 32'd0);
      check("to_retired",   bus.retired, model_retired);
      bus.run = 1'b0;
      @(negedge clock);
      bus.run = 1'b1;
      run_instr(32'h00000013, 0, 0);
      check("to_sticky", 32'(bus.bus_error), 32'd1);

      // Asynchronous reset while a load sits in MEM.
      exp_q.push_back(make_exp(32'h0000A203, 0, 0));
      wait_req(0, ok);
      ack_req(0, 32'h0000A203);
      wait_req(1, ok);
      exp_q.delete();
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("arst_data_req",  32'(bus.data_req), 32'd0);
      check("arst_retired",   bus.retired, 32'd0);
      check("arst_busy",      32'(bus.busy), 32'd0);
      check("arst_bus_error", 32'(bus.bus_error), 32'd0);
      model_retired = 0;
      @(negedge clock);
      reset = 1'b0;
      run_instr(32'h00308093, 0, 0);

      bus.run = 1'b0;
      repeat (3) @(negedge clock);
      check("final_retired", bus.retired, model_retired);
      check("final_busy",    32'(bus.busy), 32'd0);
      check("final_queue",   exp_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
